// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader and the core decoder.
package imem_loader_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned OPC_W  = 3;
    localparam int unsigned ERR_W  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LEN  = 2'd1,
        DATA = 2'd2,
        CSUM = 2'd3
    } state_t;

    localparam logic [OPC_W-1:0] OP_LOAD  = 3'b001;
    localparam logic [OPC_W-1:0] OP_ADD   = 3'b010;
    localparam logic [OPC_W-1:0] OP_STORE = 3'b100;

    localparam logic [ERR_W-1:0] ERR_NONE = 2'b00;
    localparam logic [ERR_W-1:0] ERR_ZLEN = 2'b01;
    localparam logic [ERR_W-1:0] ERR_OPC  = 2'b10;
    localparam logic [ERR_W-1:0] ERR_CSUM = 2'b11;

    // Opcode lives in the top three bits of an instruction byte.
    function automatic logic opcode_legal(input logic [BYTE_W-1:0] instr);
        logic [OPC_W-1:0] opc;
        opc = instr[BYTE_W-1 -: OPC_W];
        return (opc == OP_LOAD) || (opc == OP_ADD) || (opc == OP_STORE);
    endfunction

endpackage

// File: rtl/loader_csum_acc.sv
// 8-bit modulo-256 running sum over the loader frame (LEN, payload, CSUM).
module loader_csum_acc
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              add_en,
    input  logic [BYTE_W-1:0] add_val,
    output logic              sum_is_zero
);

    logic [BYTE_W-1:0] sum;
    logic [BYTE_W-1:0] sum_with_val;

    assign sum_with_val = BYTE_W'(sum + add_val);

    // Tests the sum including the byte on add_val so the checksum byte is judged on arrival.
    assign sum_is_zero = (sum_with_val == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum <= '0;
        end else if (clr) begin
            sum <= '0;
        end else if (add_en) begin
            sum <= sum_with_val;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed, checksummed byte frame into instruction memory while holding the core in reset.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic [ERR_W-1:0]  err_code
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    state_t              state, state_nxt;
    logic [BYTE_W-1:0]   cnt, cnt_nxt;
    logic [ADDR_W-1:0]   waddr, waddr_nxt;
    logic                we_nxt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [DATA_W-1:0]   wdata_nxt;
    logic                core_rst_nxt;
    logic                busy_nxt;
    logic                done_nxt;
    logic [ERR_W-1:0]    err_nxt;
    logic                csum_clr;
    logic                csum_add;
    logic                sum_is_zero;
    logic                hs;
    logic [BYTE_W-1:0]   in_byte;

    assign in_ready = (state != IDLE);
    assign hs       = in_valid & in_ready;
    assign in_byte  = BYTE_W'(in_data);

    loader_csum_acc u_csum (
        .clk         (clk),
        .rst         (rst),
        .clr         (csum_clr),
        .add_en      (csum_add),
        .add_val     (in_byte),
        .sum_is_zero (sum_is_zero)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        waddr_nxt    = waddr;
        we_nxt       = 1'b0;
        addr_nxt     = imem_addr;
        wdata_nxt    = imem_wdata;
        core_rst_nxt = core_rst;
        done_nxt     = 1'b0;
        err_nxt      = err_code;
        csum_clr     = 1'b0;
        csum_add     = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt    = LEN;
                    err_nxt      = ERR_NONE;
                    core_rst_nxt = 1'b1;
                    waddr_nxt    = BASE;
                    csum_clr     = 1'b1;
                end
            end
            LEN: begin
                if (hs) begin
                    csum_add = 1'b1;
                    if (in_byte == '0) begin
                        err_nxt   = ERR_ZLEN;
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt   = in_byte;
                        state_nxt = DATA;
                    end
                end
            end
            DATA: begin
                if (hs) begin
                    csum_add  = 1'b1;
                    we_nxt    = 1'b1;
                    addr_nxt  = waddr;
                    wdata_nxt = in_data;
                    waddr_nxt = ADDR_W'(waddr + 1'b1);
                    cnt_nxt   = BYTE_W'(cnt - 1'b1);
                    if (!opcode_legal(in_byte) && (err_code == ERR_NONE)) begin
                        err_nxt = ERR_OPC;
                    end
                    if (cnt == BYTE_W'(1)) begin
                        state_nxt = CSUM;
                    end
                end
            end
            CSUM: begin
                if (hs) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                    if ((err_code == ERR_NONE) && !sum_is_zero) begin
                        err_nxt = ERR_CSUM;
                    end
                    core_rst_nxt = !((err_code == ERR_NONE) && sum_is_zero);
                end
            end
            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            waddr      <= BASE;
            imem_we    <= 1'b0;
            imem_addr  <= BASE;
            imem_wdata <= '0;
            core_rst   <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            waddr      <= waddr_nxt;
            imem_we    <= we_nxt;
            imem_addr  <= addr_nxt;
            imem_wdata <= wdata_nxt;
            core_rst   <= core_rst_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            err_code   <= err_nxt;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: two instances (base 00 and FE) share one stream and are checked against a frame-level model.
module tb_imem_loader;

    typedef logic [7:0] bq_t [$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;

    logic        in_ready0, imem_we0, core_rst0, busy0, done0;
    logic [7:0]  imem_addr0, imem_wdata0;
    logic [1:0]  err_code0;
    logic        in_ready1, imem_we1, core_rst1, busy1, done1;
    logic [7:0]  imem_addr1, imem_wdata1;
    logic [1:0]  err_code1;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned cyc = 0;
    int unsigned done_cnt0 = 0;
    int unsigned done_cnt1 = 0;
    logic [15:0] wq0 [$];
    logic [15:0] wq1 [$];
    int unsigned wc0 [$];
    int unsigned wc1 [$];

    imem_loader #(.ADDR_W(8), .DATA_W(8), .BASE_ADDR(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready0), .imem_we(imem_we0), .imem_addr(imem_addr0), .imem_wdata(imem_wdata0),
        .core_rst(core_rst0), .busy(busy0), .done(done0), .err_code(err_code0)
    );

    imem_loader #(.ADDR_W(8), .DATA_W(8), .BASE_ADDR(32'hFE)) dut1 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready1), .imem_we(imem_we1), .imem_addr(imem_addr1), .imem_wdata(imem_wdata1),
        .core_rst(core_rst1), .busy(busy1), .done(done1), .err_code(err_code1)
    );

    always #5 clk = ~clk;

    // Record every write and done pulse with its cycle stamp.
    always @(negedge clk) begin
        cyc++;
        if (imem_we0) begin wq0.push_back({imem_addr0, imem_wdata0}); wc0.push_back(cyc); end
        if (imem_we1) begin wq1.push_back({imem_addr1, imem_wdata1}); wc1.push_back(cyc); end
        if (done0) done_cnt0++;
        if (done1) done_cnt1++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Frame-level reference: first error wins, checksum over the whole frame.
    function automatic logic [1:0] exp_err(input bq_t f);
        int unsigned len;
        int unsigned s;
        logic [2:0] opc;
        len = f[0];
        if (len == 0) return 2'b01;
        for (int i = 1; i <= int'(len); i++) begin
            opc = f[i][7:5];
            if (!(opc == 3'b001 || opc == 3'b010 || opc == 3'b100)) return 2'b10;
        end
        s = 0;
        for (int i = 0; i < f.size(); i++) s += f[i];
        if ((s % 256) != 0) return 2'b11;
        return 2'b00;
    endfunction

    task automatic check_writes(input string tag, input logic [15:0] got[$], input int unsigned stamps[$],
                                input bq_t f, input logic [7:0] base, input bit gaps);
        int unsigned len;
        logic [7:0] a;
        len = f[0];
        check_eq({tag, "_count"}, got.size(), len);
        for (int i = 0; i < int'(len) && i < got.size(); i++) begin
            a = 8'(int'(base) + i);
            check_eq({tag, "_addr_data"}, got[i], {a, f[i+1]});
            if (!gaps && i > 0) check_eq({tag, "_b2b"}, stamps[i] - stamps[i-1], 1);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int unsigned n;
        if (gaps) begin
            n = $urandom_range(0, 2);
            repeat (n) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                start    = ($urandom_range(0, 3) == 0);
                step();
            end
        end
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        check_eq("in_ready", in_ready0, 1);
        step();
    endtask

    task automatic run_frame(input bq_t f, input bit gaps);
        logic [1:0] e;
        int unsigned d0, d1, len;
        e   = exp_err(f);
        len = f[0];
        wq0.delete(); wq1.delete(); wc0.delete(); wc1.delete();
        d0 = done_cnt0; d1 = done_cnt1;
        // A byte offered together with start must not be taken.
        start = 1'b1; in_valid = 1'b1; in_data = 8'hA5;
        step();
        start = 1'b0;
        check_eq("busy_after_start", {busy0, busy1}, 2'b11);
        check_eq("core_rst_after_start", {core_rst0, core_rst1}, 2'b11);
        check_eq("err_cleared", {err_code0, err_code1}, 4'b0000);
        foreach (f[i]) send_byte(f[i], gaps);
        in_valid = 1'b0;
        check_eq("done", {done0, done1}, 2'b11);
        check_eq("err0", err_code0, e);
        check_eq("err1", err_code1, e);
        check_eq("core_rst0", core_rst0, (e != 2'b00));
        check_eq("core_rst1", core_rst1, (e != 2'b00));
        check_eq("busy_end", {busy0, busy1}, 2'b00);
        if (len > 0) begin
            check_eq("addr_hold0", imem_addr0, 8'(len - 1));
            check_eq("addr_hold1", imem_addr1, 8'(32'hFE + len - 1));
        end
        check_writes("wr0", wq0, wc0, f, 8'h00, gaps);
        check_writes("wr1", wq1, wc1, f, 8'hFE, gaps);
        step();
        check_eq("done_pulse_width", {done0, done1}, 2'b00);
        check_eq("core_rst_hold", core_rst0, (e != 2'b00));
        check_eq("done_count0", done_cnt0 - d0, 1);
        check_eq("done_count1", done_cnt1 - d1, 1);
    endtask

    task automatic rand_frame(input int unsigned len, output bq_t f);
        logic [7:0] b;
        logic [2:0] opc;
        int unsigned s;
        int unsigned pick;
        f.delete();
        f.push_back(8'(len));
        s = len;
        for (int i = 0; i < int'(len); i++) begin
            if ($urandom_range(0, 99) < 85) begin
                pick = $urandom_range(0, 2);
                opc = (pick == 0) ? 3'b001 : (pick == 1) ? 3'b010 : 3'b100;
            end else begin
                opc = 3'($urandom);
            end
            b = {opc, 5'($urandom)};
            f.push_back(b);
            s += b;
        end
        if (len > 0) begin
            b = 8'(0 - s);
            if ($urandom_range(0, 3) == 0) b = 8'(b + $urandom_range(1, 255));
            f.push_back(b);
        end
    endtask

    initial begin
        bq_t f;
        bq_t g;
        int unsigned d0;

        repeat (2) step();
        check_eq("rst_in_ready", {in_ready0, in_ready1}, 2'b00);
        check_eq("rst_we", {imem_we0, imem_we1}, 2'b00);
        check_eq("rst_addr0", imem_addr0, 8'h00);
        check_eq("rst_addr1", imem_addr1, 8'hFE);
        check_eq("rst_wdata", {imem_wdata0, imem_wdata1}, 16'h0000);
        check_eq("rst_core_rst", {core_rst0, core_rst1}, 2'b11);
        check_eq("rst_busy_done", {busy0, busy1, done0, done1}, 4'b0000);
        check_eq("rst_err", {err_code0, err_code1}, 4'b0000);
        rst = 1'b0;
        step();

        // Directed frames.
        f = '{8'h03, 8'h22, 8'h58, 8'h90, 8'hF3}; run_frame(f, 1'b0);
        f = '{8'h03, 8'h22, 8'h58, 8'h90, 8'hF4}; run_frame(f, 1'b0);
        f = '{8'h01, 8'hE0, 8'h1F};               run_frame(f, 1'b0);
        f = '{8'h00};                              run_frame(f, 1'b0);
        f = '{8'h03, 8'h22, 8'h58, 8'h90, 8'hF3}; run_frame(f, 1'b0);
        f = '{8'h03, 8'h22, 8'h22, 8'h22, 8'h97}; run_frame(f, 1'b0);
        f = '{8'h03, 8'h22, 8'h22, 8'h22, 8'h93}; run_frame(f, 1'b1);

        // Abort by rst after the second payload byte, valid toggling every other cycle.
        g = '{8'h03, 8'h22, 8'h58, 8'h90, 8'hF3};
        wq0.delete(); wq1.delete(); wc0.delete(); wc1.delete();
        d0 = done_cnt0;
        start = 1'b1; in_valid = 1'b0; step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b0;
            step();
            send_byte(g[i], 1'b0);
        end
        in_data = g[3];
        rst = 1'b1;
        #1;
        check_eq("abort_we", {imem_we0, imem_we1}, 2'b00);
        check_eq("abort_addr0", imem_addr0, 8'h00);
        check_eq("abort_addr1", imem_addr1, 8'hFE);
        check_eq("abort_wdata", imem_wdata0, 8'h00);
        check_eq("abort_core_rst", {core_rst0, core_rst1}, 2'b11);
        check_eq("abort_busy_done", {busy0, busy1, done0, done1}, 4'b0000);
        check_eq("abort_err", err_code0, 2'b00);
        check_eq("abort_in_ready", in_ready0, 1'b0);
        step(); step();
        check_eq("abort_wr_count0", wq0.size(), 2);
        check_eq("abort_wr_count1", wq1.size(), 2);
        if (wq0.size() == 2) begin
            check_eq("abort_wr0_0", wq0[0], 16'h0022);
            check_eq("abort_wr0_1", wq0[1], 16'h0158);
        end
        check_eq("abort_no_done", done_cnt0 - d0, 0);
        rst = 1'b0; in_valid = 1'b0;
        step();

        f = '{8'h03, 8'h22, 8'h58, 8'h90, 8'hF3}; run_frame(f, 1'b1);

        // Randomized frames.
        for (int k = 0; k < 40; k++) begin
            int unsigned len;
            int unsigned r;
            r = $urandom_range(0, 99);
            len = (r < 10) ? 0 : (r < 80) ? $urandom_range(1, 12) : $urandom_range(13, 40);
            rand_frame(len, f);
            run_frame(f, 1'($urandom_range(0, 1)));
        end
        rand_frame(255, f);
        run_frame(f, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
